// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add controller for k*P; drives an external point-op unit
// one operation at a time and keeps the running point's infinity as a separate flag.
module scalar_mult_ctrl #(
  parameter int N = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] p,
  input  logic [N-1:0] k,
  input  logic [N-1:0] px,
  input  logic [N-1:0] py,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] qx,
  output logic [N-1:0] qy,
  output logic         q_inf,
  output logic         op_req,
  output logic         op_sel,
  output logic [N-1:0] op_p,
  output logic [N-1:0] op_x1,
  output logic [N-1:0] op_y1,
  output logic [N-1:0] op_x2,
  output logic [N-1:0] op_y2,
  input  logic         op_done,
  input  logic [N-1:0] op_x3,
  input  logic [N-1:0] op_y3,
  input  logic         op_inf
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SCAN     = 3'd1;
  localparam logic [2:0] DBL_REQ  = 3'd2;
  localparam logic [2:0] DBL_WAIT = 3'd3;
  localparam logic [2:0] ADD_REQ  = 3'd4;
  localparam logic [2:0] ADD_WAIT = 3'd5;
  localparam logic [2:0] NEXT     = 3'd6;
  localparam logic [2:0] FIN      = 3'd7;

  logic [2:0]    state;
  logic [N-1:0]  k_q, px_q, py_q;
  logic [N-1:0]  rx, ry;
  logic          r_inf;
  logic [IW-1:0] idx;
  logic          bit_set;
  logic          r_is_p;

  assign bit_set = k_q[idx];
  assign r_is_p  = (rx == px_q) && (ry == py_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      op_req <= 1'b0;
      op_sel <= 1'b0;
      qx     <= '0;
      qy     <= '0;
      q_inf  <= 1'b1;
      r_inf  <= 1'b1;
      rx     <= '0;
      ry     <= '0;
      k_q    <= '0;
      px_q   <= '0;
      py_q   <= '0;
      idx    <= '0;
      op_p   <= '0;
      op_x1  <= '0;
      op_y1  <= '0;
      op_x2  <= '0;
      op_y2  <= '0;
    end else begin
      done   <= 1'b0;
      op_req <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_q   <= k;
            px_q  <= px;
            py_q  <= py;
            op_p  <= p;
            idx   <= IW'(N - 1);
            r_inf <= 1'b1;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          // Doubling infinity is infinity, so no op is needed while R is still O.
          if (r_inf) state <= bit_set ? ADD_REQ : NEXT;
          else       state <= DBL_REQ;
        end
        DBL_REQ: begin
          op_req <= 1'b1;
          op_sel <= 1'b1;
          op_x1  <= rx;
          op_y1  <= ry;
          op_x2  <= rx;
          op_y2  <= ry;
          state  <= DBL_WAIT;
        end
        DBL_WAIT: begin
          if (op_done) begin
            rx    <= op_x3;
            ry    <= op_y3;
            r_inf <= op_inf;
            state <= bit_set ? ADD_REQ : NEXT;
          end
        end
        ADD_REQ: begin
          if (r_inf) begin
            rx    <= px_q;
            ry    <= py_q;
            r_inf <= 1'b0;
            state <= NEXT;
          end else begin
            // The add formula is undefined for R==P, so that case becomes a double.
            op_req <= 1'b1;
            op_x1  <= rx;
            op_y1  <= ry;
            if (r_is_p) begin
              op_sel <= 1'b1;
              op_x2  <= rx;
              op_y2  <= ry;
            end else begin
              op_sel <= 1'b0;
              op_x2  <= px_q;
              op_y2  <= py_q;
            end
            state <= ADD_WAIT;
          end
        end
        ADD_WAIT: begin
          if (op_done) begin
            rx    <= op_x3;
            ry    <= op_y3;
            r_inf <= op_inf;
            state <= NEXT;
          end
        end
        NEXT: begin
          if (idx == '0) begin
            state <= FIN;
          end else begin
            idx   <= idx - 1'b1;
            state <= SCAN;
          end
        end
        FIN: begin
          qx    <= rx;
          qy    <= ry;
          q_inf <= r_inf;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/scalar_mult_ctrl.md
SCALAR_MULT_CTRL -- requirements
Module: scalar_mult_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 231, giving the coordinate, modulus and scalar width in bits.
REQ-002 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to compute k*P; honoured only in IDLE.
REQ-005 p, k, px, py  input  N each  field modulus, scalar, base point P=(px,py); captured on an accepted start.
REQ-006 busy  output  1  high from the cycle after an accepted start until done.
REQ-007 done  output  1  one-cycle pulse; qx, qy, q_inf are valid in that cycle and afterwards.
REQ-008 qx, qy  output  N each  result coordinates; q_inf output 1, high when the result is the point at infinity.
REQ-009 op_req, op_sel  output  1 each  point-operation request pulse; op_sel 0 = add, 1 = double.
REQ-010 op_p, op_x1, op_y1, op_x2, op_y2  output  N each  operands to the external point-operation unit.
REQ-011 op_done  input  1  one-cycle completion pulse from the unit; op_x3, op_y3 input N each, op_inf input 1 give its result.

Function
REQ-012 The block SHALL compute Q=k*P using left-to-right double-and-add over bits N-1 down to 0. The running point R starts at infinity; for each bit, R=2R, then R=R+P if the bit is 1.
REQ-013 R SHALL be held as (rx, ry, r_inf); infinity SHALL never be encoded in coordinate values.
REQ-014 FSM states: IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, NEXT, FIN.
REQ-015 IDLE: when start is high, the block SHALL latch p, k, px, py, set the bit index to N-1 and r_inf=1, then go to SCAN.
REQ-016 SCAN: if r_inf=1, the doubling SHALL be skipped locally with no op issued, then go to ADD_REQ if the current bit is 1 else NEXT. Otherwise go to DBL_REQ.
REQ-017 DBL_REQ: op_req=1 for exactly one cycle with op_sel=1, op_x1=op_x2=rx, op_y1=op_y2=ry; then go to DBL_WAIT.
REQ-018 ADD_REQ: if r_inf=1, R:=P locally with no op issued, then NEXT.
REQ-019 ADD_REQ: if rx==px and ry==py, the block SHALL issue a double of R (op_sel=1) instead of an add.
REQ-020 ADD_REQ otherwise: op_req pulse with op_sel=0, (op_x1,op_y1)=R, (op_x2,op_y2)=P; then ADD_WAIT.
REQ-021 In the WAIT states, op_x*/op_y*/op_sel/op_p SHALL stay stable until op_done. On op_done the block SHALL load R from op_x3/op_y3/op_inf.
REQ-022 After DBL_WAIT completes, go to ADD_REQ if the current bit is 1 else NEXT. After ADD_WAIT completes, go to NEXT.
REQ-023 NEXT: if the index is 0, go to FIN; else decrement the index and go to SCAN.
REQ-024 FIN: the block SHALL copy R to qx/qy/q_inf, pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-025 start while busy SHALL be ignored. op_done outside the WAIT states SHALL be ignored.
REQ-026 No op_req SHALL be issued while op_done is expected, i.e. at most one operation is outstanding.
REQ-027 op_p SHALL equal the latched p whenever busy=1.
REQ-028 The block SHALL perform no modular arithmetic; only equality compares and the bit-index counter of width clog2(N).

Reset
REQ-029 On reset the block SHALL enter IDLE with busy=0, done=0, op_req=0, op_sel=0, qx=qy=0, q_inf=1, r_inf=1, and all op_* operand outputs at 0.
REQ-030 Reset asserted mid-computation SHALL abort it without a done pulse. A later stray op_done SHALL have no effect.

Verification
All scenarios use N=8, p=17, curve y^2=x^3+2x+2, P=(5,1) (group order 19), and a behavioural point-op model with a 3-cycle response.
REQ-031 k=0 -> done with q_inf=1; zero op_req pulses.
REQ-032 k=1 -> done with (5,1), q_inf=0; zero op_req pulses.
REQ-033 k=3 -> one double then one add; result (10,6).
REQ-034 k=19 -> final add returns op_inf=1; result q_inf=1.
REQ-035 k=21 -> the last bit hits R==P; the bench SHALL see op_sel=1 in ADD_REQ, and the result SHALL be (6,3).
REQ-036 start k=3; assert reset during the first DBL_WAIT; inject op_done after reset -> no done pulse, busy=0. A following start with k=2 -> result (6,3).
